// File: rtl/timer_pkg.sv
// Shared types for the event timer: FSM state encoding and mode constants.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: step pulses on every (div+1)th enabled cycle.
module tick_prescaler #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               step
);

  logic [PRESC_W-1:0] pre;

  // The step fires in the same cycle the divider reaches div, together with its wrap.
  assign step = en && (pre == div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= step ? '0 : pre + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/event_timer.sv
// Programmable terminal-count timer with prescaler, one-shot/periodic mode and sticky irq.
// Optional: define EVENT_TIMER_RETRIGGER_EN to let start restart the timer while running.
module event_timer
  import timer_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [N-1:0]       period,
  input  logic [PRESC_W-1:0] presc,
  input  logic               irq_clr,
  output logic [N-1:0]       cnt,
  output logic               busy,
  output logic               done,
  output logic               tick_out,
  output logic               irq
);

  state_t             state;
  logic [N-1:0]       period_q;
  logic [PRESC_W-1:0] presc_q;
  logic               mode_q;
  logic               load;
  logic               step;

  // load: an accepted start that (re)latches the shadow registers and restarts counting.
  always_comb begin
    load = 1'b0;
    if (!stop && start) begin
`ifdef EVENT_TIMER_RETRIGGER_EN
      load = 1'b1;
`else
      load = (state != RUN);
`endif
    end
  end

  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (state == RUN),
    .div  (presc_q),
    .step (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      period_q <= '0;
      presc_q  <= '0;
      mode_q   <= MODE_ONESHOT;
      tick_out <= 1'b0;
      irq      <= 1'b0;
    end else begin
      tick_out <= 1'b0;
      // A terminal step below overrides this clear, so set wins over clear.
      if (irq_clr) irq <= 1'b0;

      if (stop) begin
        state <= IDLE;
      end else if (load) begin
        period_q <= period;
        presc_q  <= presc;
        mode_q   <= mode;
        cnt      <= '0;
        state    <= RUN;
      end else if (state == RUN && step) begin
        if (cnt == period_q) begin
          tick_out <= 1'b1;
          irq      <= 1'b1;
          if (mode_q == MODE_PERIODIC) cnt   <= '0;
          else                         state <= DONE;
        end else begin
          cnt <= cnt + N'(1);
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_event_timer.sv
// Scoreboard bench for event_timer: the driver queues hand-computed per-cycle expectations,
// an independent monitor pops and compares them after each rising edge.
module tb_event_timer;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode, irq_clr;
  logic [3:0] period, presc;
  logic [3:0] cnt;
  logic       busy, done, tick_out, irq;

  event_timer #(.N(4), .PRESC_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .presc    (presc),
    .irq_clr  (irq_clr),
    .cnt      (cnt),
    .busy     (busy),
    .done     (done),
    .tick_out (tick_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    logic        tick;
    logic        irq;
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string what, input string field, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h (cycle %0d)", what, field, act, req, cyc);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs; compare what is due now.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: stale expectation for cycle %0d seen at %0d", e.name, e.cyc, cyc);
        end else begin
          check(e.name, "cnt",  cnt,            e.cnt);
          check(e.name, "busy", {3'b0, busy},     {3'b0, e.busy});
          check(e.name, "done", {3'b0, done},     {3'b0, e.done});
          check(e.name, "tick", {3'b0, tick_out}, {3'b0, e.tick});
          check(e.name, "irq",  {3'b0, irq},      {3'b0, e.irq});
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the coming edge.
  task automatic drive(input logic r, st, sp, m, input logic [3:0] p, s, input logic ic,
                       input logic [3:0] ec, input logic eb, ed, et, ei, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; start = st; stop = sp; mode = m; period = p; presc = s; irq_clr = ic;
    e.cyc = cyc + 1; e.cnt = ec; e.busy = eb; e.done = ed; e.tick = et; e.irq = ei; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    logic       retrig;
    logic [3:0] c;
    logic       t, i;
`ifdef EVENT_TIMER_RETRIGGER_EN
    retrig = 1'b1;
`else
    retrig = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; period = '0; presc = '0; irq_clr = 1'b0;

    // Reset with random other inputs
    repeat (2) drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                     1'($urandom), 4'd0, 0, 0, 0, 0, "reset");

    // Periodic P=5 S=0: 0..5 then wrap with tick every 6 cycles
    drive(0, 1, 0, 1, 4'd5, 4'd0, 0, 4'd0, 1, 0, 0, 0, "per_start");
    for (int k = 1; k <= 14; k++)
      drive(0, 0, 0, 1, 4'd5, 4'd0, 0, 4'(k % 6), 1, 0, (k % 6) == 0, k >= 6, $sformatf("per_k%0d", k));
    drive(0, 0, 1, 1, 4'd5, 4'd0, 0, 4'd2, 0, 0, 0, 1, "stop_hold");
    drive(0, 0, 0, 1, 4'd5, 4'd0, 1, 4'd2, 0, 0, 0, 0, "irq_clr_idle");

    // One-shot P=3 S=2: terminal 12 cycles after start, then DONE holding 3
    drive(0, 1, 0, 0, 4'd3, 4'd2, 0, 4'd0, 1, 0, 0, 0, "os_start");
    for (int k = 1; k <= 11; k++)
      drive(0, 0, 0, 0, 4'd3, 4'd2, 0, 4'(k / 3), 1, 0, 0, 0, $sformatf("os_k%0d", k));
    drive(0, 0, 0, 0, 4'd3, 4'd2, 0, 4'd3, 0, 1, 1, 1, "os_term");
    repeat (2) drive(0, 0, 0, 0, 4'd3, 4'd2, 0, 4'd3, 0, 1, 0, 1, "os_done");

    // Restart from DONE; inputs changed mid-run must not matter; clear coincident with set
    drive(0, 1, 0, 0, 4'd3, 4'd2, 0, 4'd0, 1, 0, 0, 1, "os_restart");
    drive(0, 0, 0, 1, 4'd0, 4'd7, 1, 4'd0, 1, 0, 0, 0, "os_clr_run");
    for (int k = 2; k <= 11; k++)
      drive(0, 0, 0, 1, 4'd0, 4'd7, 0, 4'(k / 3), 1, 0, 0, 0, $sformatf("os2_k%0d", k));
    drive(0, 0, 0, 1, 4'd0, 4'd7, 1, 4'd3, 0, 1, 1, 1, "clr_vs_set");
    drive(0, 0, 0, 1, 4'd0, 4'd7, 1, 4'd3, 0, 1, 0, 0, "clr_done");
    drive(0, 0, 1, 1, 4'd0, 4'd7, 0, 4'd3, 0, 0, 0, 0, "done_stop");

    // stop beats start; stop beats a same-cycle terminal step (P=0 S=0 ticks every cycle)
    drive(0, 1, 1, 1, 4'd0, 4'd0, 0, 4'd3, 0, 0, 0, 0, "stop_over_start");
    drive(0, 1, 0, 1, 4'd0, 4'd0, 0, 4'd0, 1, 0, 0, 0, "p0_start");
    drive(0, 0, 0, 1, 4'd0, 4'd0, 0, 4'd0, 1, 0, 1, 1, "p0_tick1");
    drive(0, 0, 0, 1, 4'd0, 4'd0, 1, 4'd0, 1, 0, 1, 1, "p0_tick2_clr");
    drive(0, 0, 1, 1, 4'd0, 4'd0, 1, 4'd0, 0, 0, 0, 0, "stop_over_step");

    // Full-range wrap P=15, period input changed mid-run, reset at cnt=7
    drive(0, 1, 0, 1, 4'd15, 4'd0, 0, 4'd0, 1, 0, 0, 0, "wrap_start");
    for (int k = 1; k <= 23; k++)
      drive(0, 0, 0, 1, (k >= 2) ? 4'd3 : 4'd15, 4'd0, 0, 4'(k % 16), 1, 0, k == 16, k >= 16,
            $sformatf("wrap_k%0d", k));
    drive(1, 0, 0, 1, 4'd3, 4'd0, 0, 4'd0, 0, 0, 0, 0, "midrun_rst");
    drive(0, 0, 0, 1, 4'd3, 4'd0, 0, 4'd0, 0, 0, 0, 0, "after_rst");

    // start while running at cnt=4 with a new period of 2
    drive(0, 1, 0, 1, 4'd9, 4'd0, 0, 4'd0, 1, 0, 0, 0, "rt_start");
    for (int k = 1; k <= 4; k++)
      drive(0, 0, 0, 1, 4'd9, 4'd0, 0, 4'(k), 1, 0, 0, 0, $sformatf("rt_k%0d", k));
    for (int k = 5; k <= 10; k++) begin
      if (retrig) begin
        c = 4'((k - 5) % 3); t = (k == 8); i = (k >= 8);
      end else begin
        c = 4'(k % 10); t = (k == 10); i = (k >= 10);
      end
      drive(0, k == 5, 0, 1, 4'd2, 4'd0, 0, c, 1, 0, t, i, $sformatf("rt_k%0d", k));
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
